// File: rtl/instr_queue.sv
// Instruction fetch queue: buffers up to four 128-bit cache lines (16
// instructions) between the instruction cache and the dispatch stage.
//
// Handshakes:
//   line in   : a line transfers on a rising edge when cache_dout_valid=1
//               and ifq_rd_en=1 in the same cycle; otherwise the line is dropped.
//   instr out : an instruction is consumed on a rising edge when
//               dispatch_rd_en=1 and ifq_empty=0; otherwise nothing moves.
//   redirect  : jmp_branch_valid=1 overrides both handshakes for that cycle
//               and reloads pointers and PCs from jmp_branch_address.
module instr_queue (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] cache_dout,
    input  logic         cache_dout_valid,
    output logic         ifq_rd_en,
    output logic [31:0]  ifq_fetch_pc,
    input  logic         dispatch_rd_en,
    output logic [31:0]  ifq_icode,
    output logic [31:0]  ifq_pc,
    output logic         ifq_empty,
    input  logic         jmp_branch_valid,
    input  logic [31:0]  jmp_branch_address
);

    // Line storage; deliberately has no reset, pointers alone define validity.
    logic [127:0] line_mem [4];

    // wptr: [2] wrap, [1:0] line.  rptr: [4] wrap, [3:2] line, [1:0] word.
    logic [2:0] wptr;
    logic [4:0] rptr;

    logic         full;
    logic         line_wr;
    logic         instr_rd;
    logic [127:0] head_line;

    // Branch targets are word aligned, so the byte offset bits carry nothing.
    logic unused_addr_bits;
    assign unused_addr_bits = ^jmp_branch_address[1:0];

    // Occupancy is measured in whole lines: a line stays allocated until its
    // last word has been read, so a partially consumed head still blocks a slot.
    assign ifq_empty = (wptr == rptr[4:2]);
    assign full      = (wptr[1:0] == rptr[3:2]) && (wptr[2] != rptr[4]);
    assign ifq_rd_en = !full && !jmp_branch_valid;

    assign line_wr   = cache_dout_valid && ifq_rd_en;
    assign instr_rd  = dispatch_rd_en && !ifq_empty;

    assign head_line = line_mem[rptr[3:2]];

    // Select the head word out of the head line.
    always_comb begin
        ifq_icode = head_line[31:0];
        case (rptr[1:0])
            2'd0:    ifq_icode = head_line[31:0];
            2'd1:    ifq_icode = head_line[63:32];
            2'd2:    ifq_icode = head_line[95:64];
            default: ifq_icode = head_line[127:96];
        endcase
    end

    // Capture an accepted line into the slot addressed by the write pointer.
    always_ff @(posedge clk) begin
        if (line_wr) begin
            line_mem[wptr[1:0]] <= cache_dout;
        end
    end

    // Pointer and PC bookkeeping; a redirect wins over any transfer or read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr         <= '0;
            rptr         <= '0;
            ifq_fetch_pc <= '0;
            ifq_pc       <= '0;
        end else if (jmp_branch_valid) begin
            // Start the read pointer at the target word of line 0 so the words
            // in front of the target in the first fetched line are skipped.
            wptr         <= '0;
            rptr         <= {3'b000, jmp_branch_address[3:2]};
            ifq_fetch_pc <= {jmp_branch_address[31:4], 4'h0};
            ifq_pc       <= {jmp_branch_address[31:2], 2'b00};
        end else begin
            if (line_wr) begin
                wptr         <= wptr + 3'd1;
                ifq_fetch_pc <= ifq_fetch_pc + 32'd16;
            end
            if (instr_rd) begin
                rptr   <= rptr + 5'd1;
                ifq_pc <= ifq_pc + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: directed scenarios plus randomized
// traffic compared against a line-queue reference model.
module tb_instr_queue;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] cache_dout = '0;
    logic         cache_dout_valid = 1'b0;
    logic         ifq_rd_en;
    logic [31:0]  ifq_fetch_pc;
    logic         dispatch_rd_en = 1'b0;
    logic [31:0]  ifq_icode;
    logic [31:0]  ifq_pc;
    logic         ifq_empty;
    logic         jmp_branch_valid = 1'b0;
    logic [31:0]  jmp_branch_address = '0;

    instr_queue dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .cache_dout         (cache_dout),
        .cache_dout_valid   (cache_dout_valid),
        .ifq_rd_en          (ifq_rd_en),
        .ifq_fetch_pc       (ifq_fetch_pc),
        .dispatch_rd_en     (dispatch_rd_en),
        .ifq_icode          (ifq_icode),
        .ifq_pc             (ifq_pc),
        .ifq_empty          (ifq_empty),
        .jmp_branch_valid   (jmp_branch_valid),
        .jmp_branch_address (jmp_branch_address)
    );

    // Clock generation.
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: queue of resident lines, offset of the next word in
    // the head line, pending start offset for the first line after a redirect.
    logic [127:0] exp_q[$];
    int           head_off;
    int           first_off;
    logic [31:0]  m_fetch_pc;
    logic [31:0]  m_pc;

    function automatic logic [31:0] m_icode();
        logic [127:0] l;
        l = exp_q[0];
        return l[head_off*32 +: 32];
    endfunction

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        head_off   = 0;
        first_off  = 0;
        m_fetch_pc = 32'h0;
        m_pc       = 32'h0;
    endtask

    // Drive inputs for one cycle, settling just after the falling edge.
    task automatic apply(input logic v, input logic [127:0] d, input logic rd,
                         input logic j, input logic [31:0] a);
        @(negedge clk);
        cache_dout_valid   = v;
        cache_dout         = d;
        dispatch_rd_en     = rd;
        jmp_branch_valid   = j;
        jmp_branch_address = a;
        #1;
    endtask

    // Advance through the rising edge and update the model from the inputs.
    task automatic tick();
        bit rd_ok;
        bit wr_ok;
        @(posedge clk);
        if (rst_n) begin
            if (jmp_branch_valid) begin
                exp_q.delete();
                head_off   = 0;
                first_off  = int'(jmp_branch_address[3:2]);
                m_fetch_pc = {jmp_branch_address[31:4], 4'h0};
                m_pc       = {jmp_branch_address[31:2], 2'b00};
            end else begin
                rd_ok = dispatch_rd_en && (exp_q.size() > 0);
                wr_ok = cache_dout_valid && (exp_q.size() < 4);
                if (rd_ok) begin
                    m_pc = m_pc + 32'd4;
                    if (head_off == 3) begin
                        void'(exp_q.pop_front());
                        head_off = 0;
                    end else begin
                        head_off++;
                    end
                end
                if (wr_ok) begin
                    if (exp_q.size() == 0) head_off = first_off;
                    first_off = 0;
                    exp_q.push_back(cache_dout);
                    m_fetch_pc = m_fetch_pc + 32'd16;
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n            = 1'b0;
        cache_dout_valid = 1'b0;
        dispatch_rd_en   = 1'b0;
        jmp_branch_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n            = 1'b0;
        cache_dout_valid = 1'b1;
        cache_dout       = rand_line();
        dispatch_rd_en   = 1'b1;
        jmp_branch_valid = 1'b0;
        model_reset();
        #1;
        vectors++; if (ifq_empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b want 1", ifq_empty); end
        vectors++; if (ifq_rd_en !== 1'b1) begin miscompares++; $display("FAIL reset_rd_en: got %b want 1", ifq_rd_en); end
        vectors++; if (ifq_fetch_pc !== 32'h0) begin miscompares++; $display("FAIL reset_fetch_pc: got %h want 0", ifq_fetch_pc); end
        vectors++; if (ifq_pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h want 0", ifq_pc); end
        jmp_branch_valid = 1'b1;
        #1;
        vectors++; if (ifq_rd_en !== 1'b0) begin miscompares++; $display("FAIL reset_rd_en_jmp: got %b want 0", ifq_rd_en); end
        @(negedge clk);
        cache_dout_valid = 1'b0;
        dispatch_rd_en   = 1'b0;
        jmp_branch_valid = 1'b0;
        rst_n            = 1'b1;
    endtask

    task automatic test_single_line();
        logic [127:0] l;
        do_reset();
        l = rand_line();
        apply(1'b1, l, 1'b0, 1'b0, 32'h0);
        vectors++; if (ifq_rd_en !== 1'b1) begin miscompares++; $display("FAIL single_rd_en: got %b want 1", ifq_rd_en); end
        vectors++; if (ifq_fetch_pc !== 32'h0) begin miscompares++; $display("FAIL single_first_fetch: got %h want 0", ifq_fetch_pc); end
        tick();
        for (int k = 0; k < 4; k++) begin
            apply(1'b0, '0, 1'b1, 1'b0, 32'h0);
            vectors++; if (ifq_empty !== 1'b0) begin miscompares++; $display("FAIL single_empty[%0d]: got %b want 0", k, ifq_empty); end
            vectors++; if (ifq_icode !== l[k*32 +: 32]) begin miscompares++; $display("FAIL single_icode[%0d]: got %h want %h", k, ifq_icode, l[k*32 +: 32]); end
            vectors++; if (ifq_pc !== 32'(4*k)) begin miscompares++; $display("FAIL single_pc[%0d]: got %h want %h", k, ifq_pc, 32'(4*k)); end
            vectors++; if (ifq_fetch_pc !== 32'd16) begin miscompares++; $display("FAIL single_fetch_pc[%0d]: got %h want 10", k, ifq_fetch_pc); end
            tick();
        end
        apply(1'b0, '0, 1'b0, 1'b0, 32'h0);
        vectors++; if (ifq_empty !== 1'b1) begin miscompares++; $display("FAIL single_drained: got %b want 1", ifq_empty); end
        vectors++; if (ifq_pc !== 32'd16) begin miscompares++; $display("FAIL single_pc_end: got %h want 10", ifq_pc); end
        tick();
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            apply(1'b1, rand_line(), 1'b0, 1'b0, 32'h0);
            vectors++; if (ifq_rd_en !== (i < 4)) begin miscompares++; $display("FAIL fill_rd_en[%0d]: got %b want %b", i, ifq_rd_en, (i < 4)); end
            tick();
        end
        apply(1'b0, '0, 1'b0, 1'b0, 32'h0);
        vectors++; if (ifq_fetch_pc !== 32'd64) begin miscompares++; $display("FAIL fill_fetch_pc: got %h want 40", ifq_fetch_pc); end
        vectors++; if (ifq_rd_en !== 1'b0) begin miscompares++; $display("FAIL fill_full: got %b want 0", ifq_rd_en); end
        tick();
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, '0, 1'b1, 1'b0, 32'h0);
            vectors++; if (ifq_rd_en !== 1'b0) begin miscompares++; $display("FAIL fill_partial_rd_en[%0d]: got %b want 0", i, ifq_rd_en); end
            vectors++; if (ifq_icode !== m_icode()) begin miscompares++; $display("FAIL fill_icode[%0d]: got %h want %h", i, ifq_icode, m_icode()); end
            tick();
        end
        apply(1'b0, '0, 1'b0, 1'b0, 32'h0);
        vectors++; if (ifq_rd_en !== 1'b1) begin miscompares++; $display("FAIL fill_freed_rd_en: got %b want 1", ifq_rd_en); end
        vectors++; if (ifq_pc !== 32'd16) begin miscompares++; $display("FAIL fill_pc: got %h want 10", ifq_pc); end
        tick();
    endtask

    task automatic test_redirect();
        logic [127:0] l;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, rand_line(), 1'b0, 1'b0, 32'h0);
            tick();
        end
        apply(1'b1, rand_line(), 1'b1, 1'b1, 32'h0000_1028);
        vectors++; if (ifq_rd_en !== 1'b0) begin miscompares++; $display("FAIL redir_rd_en: got %b want 0", ifq_rd_en); end
        tick();
        apply(1'b0, '0, 1'b0, 1'b0, 32'h0);
        vectors++; if (ifq_empty !== 1'b1) begin miscompares++; $display("FAIL redir_empty: got %b want 1", ifq_empty); end
        vectors++; if (ifq_fetch_pc !== 32'h0000_1020) begin miscompares++; $display("FAIL redir_fetch_pc: got %h want 00001020", ifq_fetch_pc); end
        vectors++; if (ifq_pc !== 32'h0000_1028) begin miscompares++; $display("FAIL redir_pc: got %h want 00001028", ifq_pc); end
        tick();
        l = rand_line();
        apply(1'b1, l, 1'b0, 1'b0, 32'h0);
        tick();
        apply(1'b0, '0, 1'b1, 1'b0, 32'h0);
        vectors++; if (ifq_empty !== 1'b0) begin miscompares++; $display("FAIL redir_line_empty: got %b want 0", ifq_empty); end
        vectors++; if (ifq_icode !== l[95:64]) begin miscompares++; $display("FAIL redir_icode_w2: got %h want %h", ifq_icode, l[95:64]); end
        vectors++; if (ifq_pc !== 32'h0000_1028) begin miscompares++; $display("FAIL redir_pc_w2: got %h want 00001028", ifq_pc); end
        tick();
        apply(1'b0, '0, 1'b1, 1'b0, 32'h0);
        vectors++; if (ifq_icode !== l[127:96]) begin miscompares++; $display("FAIL redir_icode_w3: got %h want %h", ifq_icode, l[127:96]); end
        vectors++; if (ifq_pc !== 32'h0000_102c) begin miscompares++; $display("FAIL redir_pc_w3: got %h want 0000102c", ifq_pc); end
        tick();
        apply(1'b0, '0, 1'b0, 1'b0, 32'h0);
        vectors++; if (ifq_empty !== 1'b1) begin miscompares++; $display("FAIL redir_drained: got %b want 1", ifq_empty); end
        vectors++; if (ifq_fetch_pc !== 32'h0000_1030) begin miscompares++; $display("FAIL redir_fetch_next: got %h want 00001030", ifq_fetch_pc); end
        tick();
    endtask

    task automatic test_empty_read();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, '0, 1'b1, 1'b0, 32'h0);
            vectors++; if (ifq_empty !== 1'b1) begin miscompares++; $display("FAIL empty_rd_empty[%0d]: got %b want 1", i, ifq_empty); end
            vectors++; if (ifq_pc !== 32'h0) begin miscompares++; $display("FAIL empty_rd_pc[%0d]: got %h want 0", i, ifq_pc); end
            tick();
        end
        apply(1'b0, '0, 1'b0, 1'b1, 32'h0000_0047);
        tick();
        apply(1'b0, '0, 1'b1, 1'b0, 32'h0);
        tick();
        apply(1'b0, '0, 1'b0, 1'b0, 32'h0);
        vectors++; if (ifq_pc !== 32'h0000_0044) begin miscompares++; $display("FAIL empty_rd_redir_pc: got %h want 00000044", ifq_pc); end
        vectors++; if (ifq_fetch_pc !== 32'h0000_0040) begin miscompares++; $display("FAIL empty_rd_redir_fetch: got %h want 00000040", ifq_fetch_pc); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [127:0] l;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, rand_line(), 1'b0, 1'b0, 32'h0);
            tick();
        end
        apply(1'b1, rand_line(), 1'b1, 1'b0, 32'h0);
        rst_n = 1'b0;
        model_reset();
        #1;
        vectors++; if (ifq_empty !== 1'b1) begin miscompares++; $display("FAIL midrst_empty: got %b want 1", ifq_empty); end
        vectors++; if (ifq_fetch_pc !== 32'h0) begin miscompares++; $display("FAIL midrst_fetch_pc: got %h want 0", ifq_fetch_pc); end
        vectors++; if (ifq_pc !== 32'h0) begin miscompares++; $display("FAIL midrst_pc: got %h want 0", ifq_pc); end
        @(negedge clk);
        cache_dout_valid = 1'b0;
        dispatch_rd_en   = 1'b0;
        rst_n            = 1'b1;
        l = rand_line();
        apply(1'b1, l, 1'b0, 1'b0, 32'h0);
        vectors++; if (ifq_empty !== 1'b1) begin miscompares++; $display("FAIL midrst_stale: got %b want 1", ifq_empty); end
        tick();
        for (int k = 0; k < 4; k++) begin
            apply(1'b0, '0, 1'b1, 1'b0, 32'h0);
            vectors++; if (ifq_icode !== l[k*32 +: 32]) begin miscompares++; $display("FAIL midrst_icode[%0d]: got %h want %h", k, ifq_icode, l[k*32 +: 32]); end
            tick();
        end
        apply(1'b0, '0, 1'b0, 1'b0, 32'h0);
        vectors++; if (ifq_empty !== 1'b1) begin miscompares++; $display("FAIL midrst_drained: got %b want 1", ifq_empty); end
        tick();
    endtask

    task automatic test_random();
        logic v, rd, j;
        int   pv, pr;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            // Alternate between fill-heavy and drain-heavy phases so the
            // queue spends time both full and empty.
            pv = ((cyc / 50) % 2 == 0) ? 80 : 35;
            pr = ((cyc / 50) % 2 == 0) ? 35 : 80;
            v  = ($urandom_range(0, 99) < pv);
            rd = ($urandom_range(0, 99) < pr);
            j  = ($urandom_range(0, 99) < 3);
            apply(v, rand_line(), rd, j, $urandom);
            vectors++; if (ifq_empty !== (exp_q.size() == 0)) begin miscompares++; $display("FAIL rand_empty@%0d: got %b want %b", cyc, ifq_empty, (exp_q.size() == 0)); end
            vectors++; if (ifq_rd_en !== ((exp_q.size() < 4) && !j)) begin miscompares++; $display("FAIL rand_rd_en@%0d: got %b want %b", cyc, ifq_rd_en, ((exp_q.size() < 4) && !j)); end
            vectors++; if (ifq_fetch_pc !== m_fetch_pc) begin miscompares++; $display("FAIL rand_fetch_pc@%0d: got %h want %h", cyc, ifq_fetch_pc, m_fetch_pc); end
            vectors++; if (ifq_pc !== m_pc) begin miscompares++; $display("FAIL rand_pc@%0d: got %h want %h", cyc, ifq_pc, m_pc); end
            if (exp_q.size() > 0) begin
                vectors++; if (ifq_icode !== m_icode()) begin miscompares++; $display("FAIL rand_icode@%0d: got %h want %h", cyc, ifq_icode, m_icode()); end
            end
            tick();
        end
        apply(1'b0, '0, 1'b0, 1'b0, 32'h0);
        tick();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        test_reset();
        test_single_line();
        test_fill();
        test_redirect();
        test_empty_read();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: rst_n  input  1  asynchronous active-low reset.
REQ-003: cache_dout  input  128  fetched line at ifq_fetch_pc; word k = bits [32k+31:32k], k=0..3.
REQ-004: cache_dout_valid  input  1  cache_dout valid this cycle for the address on ifq_fetch_pc.
REQ-005: ifq_rd_en  output  1  queue ready to accept a line (combinational).
REQ-006: ifq_fetch_pc  output  32  16-byte-aligned fetch address, registered.
REQ-007: dispatch_rd_en  input  1  dispatch consumes the head instruction this cycle.
REQ-008: ifq_icode  output  32  head instruction, combinational from storage; feeds the dispatch decoder.
REQ-009: ifq_pc  output  32  PC of the head instruction, registered.
REQ-010: ifq_empty  output  1  no instruction available.
REQ-011: jmp_branch_valid  input  1  redirect request (taken branch/jump), single-cycle pulse.
REQ-012: jmp_branch_address  input  32  redirect target, word-aligned (bits [1:0] ignored).

Function
REQ-013: Storage is 4 lines x 128 bits (16 instructions).
REQ-014: Write pointer wptr is 3 bits: [2] wrap, [1:0] line index.
REQ-015: Read pointer rptr is 5 bits: [4] wrap, [3:2] line index, [1:0] word index.
REQ-016: ifq_empty = (wptr == rptr[4:2]).
REQ-017: full = (wptr[1:0] == rptr[3:2]) and (wptr[2] != rptr[4]).
REQ-018: ifq_rd_en = !full and !jmp_branch_valid.
REQ-019: Line transfer occurs when cache_dout_valid and ifq_rd_en in the same cycle; the line is written to entry wptr[1:0], wptr increments by 1 (mod 8), and ifq_fetch_pc increments by 16 (mod 2^32).
REQ-020: cache_dout_valid while ifq_rd_en=0 is ignored; no state changes.
REQ-021: ifq_icode = line[rptr[3:2]] word rptr[1:0]; its value is don't-care while ifq_empty=1.
REQ-022: Instruction read occurs when dispatch_rd_en and !ifq_empty; rptr increments by 1 (mod 32) and ifq_pc increments by 4.
REQ-023: dispatch_rd_en while ifq_empty=1 is ignored; rptr and ifq_pc hold.
REQ-024: A simultaneous line transfer and instruction read in the same cycle are both performed.
REQ-025: Reading the last word of a line frees that line; ifq_rd_en may rise in the following cycle.
REQ-026: Redirect: when jmp_branch_valid=1, the following state is loaded on the next edge:
  - wptr = 0
  - rptr = {1'b0, 2'b00, jmp_branch_address[3:2]}
  - ifq_fetch_pc = {jmp_branch_address[31:4], 4'h0}
  - ifq_pc = {jmp_branch_address[31:2], 2'b00}
REQ-027: Redirect has priority; any cache data and dispatch read in the redirect cycle are discarded.
REQ-028: After a redirect, the queue is empty until the first line is written.
REQ-029: Words of the first post-redirect line below the target offset are never presented.
REQ-030: Latency: a line written in cycle N makes its first instruction visible (ifq_empty=0) in cycle N+1.
REQ-031: Pointer wrap-around is natural modulo overflow; no pointer saturates.

Reset
REQ-032: While rst_n=0, the following values apply immediately:
  - wptr = 0, rptr = 0
  - ifq_fetch_pc = 32'h0, ifq_pc = 32'h0
  - ifq_empty = 1
  - ifq_rd_en = 1 (unless jmp_branch_valid=1)
REQ-033: Line storage is not reset.
REQ-034: Reset asserted mid-operation discards all queued instructions and any in-progress transfer.
REQ-035: The first fetch after reset is from address 0.

Verification
REQ-036: Reset, then cache_dout={I3,I2,I1,I0} valid one cycle, then dispatch_rd_en held high:
  - ifq_icode = I0, I1, I2, I3 on consecutive cycles with ifq_pc = 0, 4, 8, 12
  - ifq_empty rises after I3 is read
  - ifq_fetch_pc = 16 after the line transfer
REQ-037: cache_dout_valid held high with dispatch_rd_en=0:
  - exactly 4 lines accepted, then ifq_rd_en=0 and ifq_fetch_pc=64
  - one instruction read leaves ifq_rd_en=0
  - after 4 reads (first line freed), ifq_rd_en=1
REQ-038: With 2 lines queued, jmp_branch_valid=1 with address 32'h0000_1028 and cache_dout_valid=1 in the same cycle:
  - next cycle: ifq_empty=1, ifq_fetch_pc=32'h0000_1020, ifq_pc=32'h0000_1028
  - after the next line transfer, ifq_icode = word 2 of that line
REQ-039: Simultaneous line write and instruction read with exactly one free line:
  - both operations complete
  - instruction count stays consistent; no loss or duplication over 40 cycles of random valid/rd_en traffic
REQ-040: rst_n pulsed low while 3 lines are queued:
  - immediately ifq_empty=1, ifq_fetch_pc=0, ifq_pc=0
  - after reset release, stale lines are never presented
REQ-041: dispatch_rd_en=1 while empty: rptr and ifq_pc unchanged.
